// File: rtl/lcd_executor.sv
// Command executor for an HD44780-style 16x2 character LCD on an 8-bit write-only bus.
// Runs the power-on init by itself, then executes one sequencer command per rdy handshake.
module lcd_executor #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EN      = 12,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_WAIT2   = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [3:0] op,
  input  logic [7:0] data,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       rdy
);

  // state    | meaning
  // PWR_WAIT | power-on delay before the first init instruction
  // SETUP    | RS/DATA driven, EN low, waiting out setup time
  // PULSE    | EN high
  // DELAY    | EN low, bus held, post-command delay (also wait2 / no-op)
  // IDLE     | rdy high, waiting for enb
  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_SETUP,
    S_PULSE,
    S_DELAY,
    S_IDLE
  } state_t;

  localparam logic [31:0] L_SETUP   = 32'(T_SETUP);
  localparam logic [31:0] L_EN      = 32'(T_EN);
  localparam logic [31:0] L_CMD     = 32'(T_CMD);
  localparam logic [31:0] L_CLEAR   = 32'(T_CLEAR);
  localparam logic [31:0] L_POWERON = 32'(T_POWERON);
  localparam logic [31:0] L_WAIT2   = 32'(T_WAIT2);

  state_t      r_state, w_state;
  logic [31:0] r_cnt, w_cnt;
  logic [31:0] r_dly, w_dly;
  logic [31:0] w_len;
  logic        w_tc;
  logic        r_rs, w_rs;
  logic        r_en, w_en;
  logic [7:0]  r_data, w_data;
  logic        r_rdy, w_rdy;
  logic [1:0]  r_idx, w_idx;
  logic        r_init, w_init;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Positions 40..79 map onto line 2, which starts at DDRAM 0x40.
  function automatic logic [7:0] setad_cmd(input logic [7:0] pos);
    logic [7:0] addr;
    if (pos < 8'd40)      addr = pos;
    else if (pos < 8'd80) addr = pos + 8'd24;
    else                  addr = {1'b0, pos[6:0]};
    return {1'b1, addr[6:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_PWR_WAIT;
      r_cnt   <= '0;
      r_dly   <= '0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_idx   <= '0;
      r_init  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_dly   <= w_dly;
      r_rs    <= w_rs;
      r_en    <= w_en;
      r_data  <= w_data;
      r_rdy   <= w_rdy;
      r_idx   <= w_idx;
      r_init  <= w_init;
    end
  end

  always_comb begin
    case (r_state)
      S_PWR_WAIT: w_len = L_POWERON;
      S_SETUP:    w_len = L_SETUP;
      S_PULSE:    w_len = L_EN;
      S_DELAY:    w_len = r_dly;
      default:    w_len = 32'd1;
    endcase
  end

  assign w_tc = (r_cnt == w_len - 32'd1);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 32'd1;
    w_dly   = r_dly;
    w_rs    = r_rs;
    w_en    = r_en;
    w_data  = r_data;
    w_rdy   = r_rdy;
    w_idx   = r_idx;
    w_init  = r_init;
    case (r_state)
      S_PWR_WAIT: begin
        if (w_tc) begin
          w_state = S_SETUP;
          w_cnt   = '0;
          w_rs    = 1'b0;
          w_data  = init_cmd(2'd0);
          w_dly   = L_CMD;
          w_idx   = 2'd0;
          w_init  = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_tc) begin
          w_state = S_PULSE;
          w_cnt   = '0;
          w_en    = 1'b1;
        end
      end
      S_PULSE: begin
        if (w_tc) begin
          w_state = S_DELAY;
          w_cnt   = '0;
          w_en    = 1'b0;
        end
      end
      S_DELAY: begin
        if (w_tc) begin
          w_cnt = '0;
          if (r_init && (r_idx != 2'd3)) begin
            w_state = S_SETUP;
            w_idx   = r_idx + 2'd1;
            w_data  = init_cmd(r_idx + 2'd1);
            w_dly   = (r_idx == 2'd1) ? L_CLEAR : L_CMD;
          end else begin
            w_state = S_IDLE;
            w_rdy   = 1'b1;
            w_init  = 1'b0;
          end
        end
      end
      S_IDLE: begin
        w_cnt = '0;
        if (enb) begin
          w_rdy = 1'b0;
          case (op)
            4'd0: begin
              w_state = S_SETUP;
              w_rs    = 1'b0;
              w_data  = 8'h01;
              w_dly   = L_CLEAR;
            end
            4'd1: begin
              w_state = S_SETUP;
              w_rs    = 1'b1;
              w_data  = data;
              w_dly   = L_CMD;
            end
            4'd3: begin
              w_state = S_SETUP;
              w_rs    = 1'b0;
              w_data  = setad_cmd(data);
              w_dly   = L_CMD;
            end
            4'd4: begin
              w_state = S_DELAY;
              w_dly   = L_WAIT2;
            end
            default: begin
              // One-cycle dwell so the sequencer still sees a rdy rising edge.
              w_state = S_DELAY;
              w_dly   = 32'd1;
            end
          endcase
        end
      end
      default: begin
        w_state = S_PWR_WAIT;
        w_cnt   = '0;
      end
    endcase
  end

  assign LCD_RS   = r_rs;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = r_en;
  assign LCD_DATA = r_data;
  assign rdy      = r_rdy;

endmodule

// File: tb/tb_lcd_executor.sv
// Scoreboard bench for lcd_executor: stimulus pushes expected bus writes and rdy-low
// durations; a negedge monitor pops and compares them as the DUT produces them.
module tb_lcd_executor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] data = '0;
  logic       LCD_RS, LCD_RW, LCD_EN, rdy;
  logic [7:0] LCD_DATA;

  lcd_executor #(
    .T_SETUP(2), .T_EN(3), .T_CMD(10), .T_CLEAR(20), .T_POWERON(50), .T_WAIT2(30)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .op(op), .data(data),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA), .rdy(rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_bus_q[$];
  int         exp_low_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  logic prev_en = 1'b0, prev_rdy = 1'b0;
  bit   en_act = 0, low_act = 0;
  int   en_w = 0, low_w = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0; prev_rdy = 1'b0; en_act = 0; low_act = 0;
    end else begin
      if (LCD_EN && !prev_en) begin
        check("en_pulse_expected", int'(exp_bus_q.size() > 0), 1);
        if (exp_bus_q.size() > 0) begin
          check("bus_rs_data", int'({LCD_RS, LCD_DATA}), int'(exp_bus_q.pop_front()));
          check("bus_rw", int'(LCD_RW), 0);
        end
        en_act = 1; en_w = 0;
      end
      if (LCD_EN) en_w++;
      else if (prev_en && en_act) begin
        check("en_width", en_w, 3);
        en_act = 0;
      end
      if (!rdy && prev_rdy) begin low_act = 1; low_w = 0; end
      if (!rdy && low_act) low_w++;
      if (rdy && !prev_rdy && low_act) begin
        check("rdy_cycle_expected", int'(exp_low_q.size() > 0), 1);
        if (exp_low_q.size() > 0) check("rdy_low_cycles", low_w, exp_low_q.pop_front());
        low_act = 0;
      end
      prev_en = LCD_EN; prev_rdy = rdy;
    end
  end

  task automatic wait_rdy(input int budget);
    int n = 0;
    while (!rdy && n < budget) begin @(negedge clk); n++; end
    check("rdy_wait", int'(rdy), 1);
  endtask

  task automatic send(input logic [3:0] o, input logic [7:0] d, input bit has_bus,
                      input logic [8:0] bus, input int low);
    wait_rdy(200);
    op = o; data = d; enb = 1'b1;
    if (has_bus) exp_bus_q.push_back(bus);
    exp_low_q.push_back(low);
    @(negedge clk);
    enb = 1'b0;
    check("rdy_fell_on_capture", int'(rdy), 0);
  endtask

  task automatic push_init();
    exp_bus_q.delete(); exp_low_q.delete();
    exp_bus_q.push_back({1'b0, 8'h38});
    exp_bus_q.push_back({1'b0, 8'h0C});
    exp_bus_q.push_back({1'b0, 8'h01});
    exp_bus_q.push_back({1'b0, 8'h06});
  endtask

  task automatic release_and_time_init();
    int n = 0;
    @(negedge clk);
    rst = 1'b0;
    while (!rdy && n < 400) begin @(negedge clk); n++; end
    check("init_rdy_cycles", n, 120);
    check("init_bus_all_seen", exp_bus_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int n;
    s = "Welcome!";
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rs", int'(LCD_RS), 0);
    check("rst_rw", int'(LCD_RW), 0);
    check("rst_en", int'(LCD_EN), 0);
    check("rst_data", int'(LCD_DATA), 0);
    check("rst_rdy", int'(rdy), 0);
    push_init();
    release_and_time_init();

    send(4'd1, 8'h57, 1, {1'b1, 8'h57}, 15);
    send(4'd3, 8'd4,  1, {1'b0, 8'h84}, 15);
    send(4'd3, 8'd43, 1, {1'b0, 8'hC3}, 15);
    send(4'd3, 8'd39, 1, {1'b0, 8'hA7}, 15);
    send(4'd3, 8'd40, 1, {1'b0, 8'hC0}, 15);
    send(4'd3, 8'd79, 1, {1'b0, 8'hE7}, 15);
    send(4'd3, 8'd90, 1, {1'b0, 8'hDA}, 15);
    send(4'd0, 8'hFF, 1, {1'b0, 8'h01}, 25);
    send(4'd4, 8'h33, 0, 9'h0, 30);
    wait_rdy(100);
    check("wait2_bus_held", int'({LCD_RS, LCD_DATA}), int'({1'b0, 8'h01}));
    send(4'd2, 8'h11, 0, 9'h0, 1);
    send(4'd15, 8'h22, 0, 9'h0, 1);

    // Sequencer-style handshake, enb held high across commands
    wait_rdy(100);
    for (int i = 0; i < s.len(); i++) begin
      n = 0;
      while (!rdy && n < 100) begin @(negedge clk); n++; end
      check("hs_rdy", int'(rdy), 1);
      op = 4'd1; data = s[i]; enb = 1'b1;
      exp_bus_q.push_back({1'b1, s[i]});
      exp_low_q.push_back(15);
      @(negedge clk);
      check("hs_capture", int'(rdy), 0);
      if (i == s.len() - 1) enb = 1'b0;
    end
    wait_rdy(100);
    repeat (20) @(negedge clk);
    check("idle_rdy_after_hs", int'(rdy), 1);
    check("hs_bus_all_seen", exp_bus_q.size(), 0);
    check("hs_rdy_all_seen", exp_low_q.size(), 0);

    // Reset while EN is high
    wait_rdy(100);
    op = 4'd1; data = 8'h41; enb = 1'b1;
    exp_bus_q.push_back({1'b1, 8'h41});
    exp_low_q.push_back(15);
    @(negedge clk);
    enb = 1'b0;
    n = 0;
    while (!LCD_EN && n < 20) begin @(negedge clk); n++; end
    check("mid_en_seen", int'(LCD_EN), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", int'(LCD_EN), 0);
    check("mid_rst_rdy", int'(rdy), 0);
    check("mid_rst_data", int'(LCD_DATA), 0);
    @(negedge clk);
    push_init();
    release_and_time_init();
    repeat (5) @(negedge clk);
    check("final_rdy", int'(rdy), 1);
    check("final_rdy_q_empty", exp_low_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
